// File: rtl/hiscore_ram_arbiter.sv
// Shares one game RAM between the CPU and the hiscore engine by halting the CPU; zero-latency data mux.
// Grant follows pause acknowledge plus SETTLE guard cycles; a missing acknowledge after TMO cycles gives the RAM back to the CPU.
module hiscore_ram_arbiter #(
    parameter int AW     = 10,
    parameter int SETTLE = 4,
    parameter int TMO    = 65535
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_we,
    output logic [7:0]    cpu_dout,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_din,
    input  logic          hs_we,
    input  logic          hs_intent_read,
    input  logic          hs_intent_write,
    output logic [7:0]    hs_dout,
    output logic          hs_ready,
    output logic          pause_req,
    input  logic          paused,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    output logic          owner,
    output logic          hs_timeout
);

    typedef enum logic [2:0] {
        ST_CPU,
        ST_REQ,
        ST_SETTLE,
        ST_HS,
        ST_RELEASE
    } state_t;

    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TMO - 1);

    state_t      state_q, state_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        owner_q, owner_d;
    logic        hs_ready_q, hs_ready_d;
    logic        pause_req_q, pause_req_d;
    logic        hs_timeout_q, hs_timeout_d;
    logic        timeout_hit;
    logic        intent;

    assign intent = hs_intent_read | hs_intent_write;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_CPU;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            owner_q      <= 1'b0;
            hs_ready_q   <= 1'b0;
            pause_req_q  <= 1'b0;
            hs_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            owner_q      <= owner_d;
            hs_ready_q   <= hs_ready_d;
            pause_req_q  <= pause_req_d;
            hs_timeout_q <= hs_timeout_d;
        end
    end

    // Losing the pause acknowledge in SETTLE or HS re-arbitrates from REQ with a fresh timeout window.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        timeout_hit  = 1'b0;
        case (state_q)
            ST_CPU: begin
                if (intent) begin
                    state_d   = ST_REQ;
                    tmo_cnt_d = '0;
                end
            end
            ST_REQ: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (!intent) begin
                    state_d = ST_CPU;
                end else if (paused) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_LOAD;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = ST_CPU;
                    timeout_hit = 1'b1;
                    tmo_cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (!paused) begin
                    state_d   = ST_REQ;
                    tmo_cnt_d = '0;
                end else if (settle_cnt_q == 4'd0) begin
                    state_d = ST_HS;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            ST_HS: begin
                if (!paused) begin
                    state_d   = ST_REQ;
                    tmo_cnt_d = '0;
                end else if (!intent) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_CPU;
            default:    state_d = ST_CPU;
        endcase
    end

    // Status flags are decoded from the next state so they leave the block straight from flops.
    always_comb begin
        owner_d      = (state_d == ST_HS);
        hs_ready_d   = (state_d == ST_HS);
        pause_req_d  = (state_d != ST_CPU);
        hs_timeout_d = timeout_hit;

        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
        case (state_q)
            ST_CPU, ST_REQ: ram_we = cpu_we;
            ST_HS: begin
                ram_addr = hs_addr;
                ram_din  = hs_din;
                ram_we   = hs_we & paused;
            end
            default: ram_we = 1'b0;
        endcase
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    assign cpu_dout   = ram_dout;
    assign hs_dout    = ram_dout;
    assign owner      = owner_q;
    assign hs_ready   = hs_ready_q;
    assign pause_req  = pause_req_q;
    assign hs_timeout = hs_timeout_q;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter with a behavioural RAM holding one cycle of read latency.
module tb_hiscore_ram_arbiter;

    localparam int AW = 10;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_we;
    logic [7:0]    cpu_dout;
    logic [AW-1:0] hs_addr;
    logic [7:0]    hs_din;
    logic          hs_we;
    logic          hs_intent_read;
    logic          hs_intent_write;
    logic [7:0]    hs_dout;
    logic          hs_ready;
    logic          pause_req;
    logic          paused;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout = 8'h00;
    logic          owner;
    logic          hs_timeout;

    logic [7:0] mem [0:(1<<AW)-1] = '{default: 8'h00};

    int total = 0;
    int bad   = 0;

    hiscore_ram_arbiter #(.AW(AW), .SETTLE(4), .TMO(16)) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .cpu_addr        (cpu_addr),
        .cpu_din         (cpu_din),
        .cpu_we          (cpu_we),
        .cpu_dout        (cpu_dout),
        .hs_addr         (hs_addr),
        .hs_din          (hs_din),
        .hs_we           (hs_we),
        .hs_intent_read  (hs_intent_read),
        .hs_intent_write (hs_intent_write),
        .hs_dout         (hs_dout),
        .hs_ready        (hs_ready),
        .pause_req       (pause_req),
        .paused          (paused),
        .ram_addr        (ram_addr),
        .ram_din         (ram_din),
        .ram_we          (ram_we),
        .ram_dout        (ram_dout),
        .owner           (owner),
        .hs_timeout      (hs_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic early;
        reset = 1'b1;
        cpu_addr = 10'h005; cpu_din = 8'h77; cpu_we = 1'b1;
        hs_addr = '0; hs_din = '0; hs_we = 1'b0;
        hs_intent_read = 1'b0; hs_intent_write = 1'b0; paused = 1'b0;
        #1;
        chk("rst_ram_we", ram_we, 0);
        tick(); tick();
        chk("rst_owner", owner, 0);
        chk("rst_hs_ready", hs_ready, 0);
        chk("rst_pause_req", pause_req, 0);
        chk("rst_hs_timeout", hs_timeout, 0);
        chk("rst_no_write", mem[10'h005], 8'h00);

        // CPU owns the RAM on the first cycle after reset
        reset = 1'b0;
        tick();
        chk("cpu_first_write", mem[10'h005], 8'h77);
        cpu_addr = 10'h010; cpu_din = 8'h3C;
        tick();
        cpu_we = 1'b0;

        // Basic grant: paused arrives three cycles into REQ
        hs_intent_write = 1'b1; hs_we = 1'b1; hs_addr = 10'h1F0; hs_din = 8'hA5;
        cpu_we = 1'b1; cpu_addr = 10'h020; cpu_din = 8'h11;
        tick();
        chk("req_pause_req", pause_req, 1);
        chk("req_hs_ready", hs_ready, 0);
        chk("req_owner", owner, 0);
        tick(); tick();
        chk("req_cpu_write", mem[10'h020], 8'h11);
        paused = 1'b1;
        tick();
        cpu_addr = 10'h030; cpu_din = 8'h22;
        chk("settle_ram_we", ram_we, 0);
        chk("settle_pause_req", pause_req, 1);
        tick(); tick(); tick();
        chk("settle_not_ready_3", hs_ready, 0);
        tick();
        chk("grant_hs_ready_4", hs_ready, 1);
        chk("grant_owner", owner, 1);
        chk("hs_ram_addr", ram_addr, 10'h1F0);
        chk("hs_ram_we", ram_we, 1);
        tick();
        chk("hs_write_done", mem[10'h1F0], 8'hA5);
        chk("hs_cpu_blocked", mem[10'h030], 8'h00);

        // Read path, RELEASE, and intents rising as RELEASE completes
        hs_we = 1'b0; hs_addr = 10'h010;
        tick();
        chk("hs_dout", hs_dout, 8'h3C);
        chk("cpu_dout", cpu_dout, 8'h3C);
        hs_intent_write = 1'b0;
        tick();
        chk("rel_owner", owner, 0);
        chk("rel_hs_ready", hs_ready, 0);
        chk("rel_pause_req", pause_req, 1);
        chk("rel_ram_we", ram_we, 0);
        hs_intent_read = 1'b1;
        tick();
        chk("post_rel_pause_req", pause_req, 0);
        chk("post_rel_owner", owner, 0);
        chk("rel_cpu_blocked", mem[10'h030], 8'h00);
        cpu_we = 1'b0; paused = 1'b0;
        tick();
        chk("rereq_pause_req", pause_req, 1);
        hs_intent_read = 1'b0;
        tick();
        chk("abandon_pause_req", pause_req, 0);

        // Timeout with paused held low; CPU keeps writing
        cpu_we = 1'b1; cpu_addr = 10'h040; cpu_din = 8'h5A;
        hs_intent_read = 1'b1;
        tick();
        early = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            early = early | hs_timeout;
        end
        chk("tmo_no_early_pulse", early, 0);
        tick();
        chk("tmo_pulse", hs_timeout, 1);
        chk("tmo_pause_req", pause_req, 0);
        chk("tmo_cpu_write", mem[10'h040], 8'h5A);
        tick();
        chk("tmo_pulse_width", hs_timeout, 0);
        chk("tmo_rereq", pause_req, 1);
        hs_intent_read = 1'b0; cpu_we = 1'b0;
        tick();

        // Pause loss in HS with a write pending
        hs_intent_write = 1'b1; hs_addr = 10'h050; hs_din = 8'h99; paused = 1'b1;
        tick(); tick();
        tick(); tick(); tick(); tick();
        chk("pl_grant", hs_ready, 1);
        hs_we = 1'b1; paused = 1'b0;
        #1;
        chk("pl_ram_we", ram_we, 0);
        tick();
        chk("pl_hs_ready", hs_ready, 0);
        chk("pl_req_pause", pause_req, 1);
        chk("pl_no_write", mem[10'h050], 8'h00);
        paused = 1'b1;
        tick();
        tick(); tick(); tick();
        chk("pl_settle_again", hs_ready, 0);
        tick();
        chk("pl_regrant", hs_ready, 1);
        tick();
        chk("pl_write_after", mem[10'h050], 8'h99);

        // Reset during an HS write
        hs_addr = 10'h060; hs_din = 8'hEE; hs_we = 1'b1; reset = 1'b1;
        #1;
        chk("rst_hs_ram_we", ram_we, 0);
        tick();
        chk("rst_hs_no_write", mem[10'h060], 8'h00);
        chk("rst_hs_owner", owner, 0);
        chk("rst_hs_ready", hs_ready, 0);
        chk("rst_hs_pause", pause_req, 0);
        chk("rst_hs_timeout", hs_timeout, 0);
        reset = 1'b0; hs_we = 1'b0; hs_intent_write = 1'b0; paused = 1'b0;
        cpu_we = 1'b1; cpu_addr = 10'h070; cpu_din = 8'h12;
        tick();
        chk("rst_cpu_mux", mem[10'h070], 8'h12);
        cpu_we = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
